pwm_capture: RTL and testbench

Input-capture counterpart to the 3-channel PWM controller. It measures the period and high time of one external PWM signal, in prescaled tick units, and reports each complete measurement with a one-cycle valid pulse. It is used for loopback checking of PWM outputs and for reading external PWM sensors. Register-level control comes from the same control block that drives the PWM controller.

---
 rtl/pwm_capture.sv | 154 +++++++++++++++
 tb/tb_pwm_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of pwm_in in prescaled ticks.
// Optional macro PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample glitch filter after the synchronizer.
module pwm_capture #(
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pwm_in,
  input  logic                 capture_enable,
  input  logic [7:0]           prescaler,
  output logic [CNT_WIDTH-1:0] measured_period,
  output logic [CNT_WIDTH-1:0] measured_high,
  output logic                 capture_valid,
  output logic                 capture_overflow,
  output logic                 signal_level,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_raw;
  logic                   s;
  logic [7:0]             presc_cnt;
  logic                   tick;
  logic                   prev;
  logic                   rise;
  logic                   fall;
  logic                   en_q;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   high_lat;
  logic [CNT_WIDTH-1:0]   cnt_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign s_raw = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // Level follows the raw input only once three consecutive samples agree.
  assign s = (s_raw == hist_q[0] && s_raw == hist_q[1]) ? s_raw : filt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], s_raw};
      filt_q <= s;
    end
  end
`else
  assign s = s_raw;
`endif

  assign tick = capture_enable && (presc_cnt == 8'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            presc_cnt <= 8'd0;
    else if (!capture_enable) presc_cnt <= 8'd0;
    else if (tick)           presc_cnt <= prescaler;
    else                     presc_cnt <= presc_cnt - 8'd1;
  end

  assign rise     = tick &  s & ~prev;
  assign fall     = tick & ~s &  prev;
  assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      cnt              <= '0;
      high_lat         <= '0;
      prev             <= 1'b0;
      en_q             <= 1'b0;
      measured_period  <= '0;
      measured_high    <= '0;
      capture_valid    <= 1'b0;
      capture_overflow <= 1'b0;
      signal_level     <= 1'b0;
    end else begin
      capture_valid <= 1'b0;
      en_q          <= capture_enable;
      if (tick) signal_level <= s;
      if (!capture_enable) begin
        state <= IDLE;
        cnt   <= '0;
        prev  <= s;
      end else begin
        if (!en_q) capture_overflow <= 1'b0;
        // Outside IDLE, prev is only updated on ticks so edges are seen in tick time.
        if (state == IDLE || tick) prev <= s;
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= WAIT_RISE;
          end
          WAIT_RISE: begin
            if (rise) begin
              cnt   <= CNT_ONE;
              state <= MEAS_HIGH;
            end
          end
          MEAS_HIGH: begin
            if (fall) begin
              high_lat <= cnt;
              cnt      <= cnt_next;
              state    <= MEAS_LOW;
            end else if (tick && cnt == CNT_MAX) begin
              capture_overflow <= 1'b1;
              cnt              <= '0;
              state            <= WAIT_RISE;
            end else if (tick) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              measured_period <= cnt;
              measured_high   <= high_lat;
              capture_valid   <= 1'b1;
              cnt             <= CNT_ONE;
              state           <= MEAS_HIGH;
            end else if (tick && cnt == CNT_MAX) begin
              capture_overflow <= 1'b1;
              cnt              <= '0;
              state            <= WAIT_RISE;
            end else if (tick) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: expected {period, high} pairs are queued by
// the stimulus and checked by a monitor whenever capture_valid pulses.
module tb_pwm_capture;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         pwm_in;
  logic         capture_enable;
  logic [7:0]   prescaler;
  logic [W-1:0] measured_period;
  logic [W-1:0] measured_high;
  logic         capture_valid;
  logic         capture_overflow;
  logic         signal_level;
  logic [1:0]   state_dbg;

  logic [2*W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  pwm_capture #(.CNT_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pwm_in           (pwm_in),
    .capture_enable   (capture_enable),
    .prescaler        (prescaler),
    .measured_period  (measured_period),
    .measured_high    (measured_high),
    .capture_valid    (capture_valid),
    .capture_overflow (capture_overflow),
    .signal_level     (signal_level),
    .state_dbg        (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_pwm(input logic lvl, input int n);
    pwm_in = lvl;
    wait_clks(n);
  endtask

  task automatic expect_meas(input logic [W-1:0] per, input logic [W-1:0] hi);
    exp_q.push_back({per, hi});
  endtask

  task automatic check(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && capture_valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_valid: actual period=%0d high=%0d required no capture_valid",
                 measured_period, measured_high);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if ({measured_period, measured_high} != e) begin
          tests_failed++;
          $display("FAIL capture: actual period=%0d high=%0d required period=%0d high=%0d",
                   measured_period, measured_high, e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_period"},   measured_period, 0);
    check({tag, "_high"},     measured_high, 0);
    check({tag, "_valid"},    capture_valid, 0);
    check({tag, "_overflow"}, capture_overflow, 0);
    check({tag, "_level"},    signal_level, 0);
  endtask

  task automatic idle_gap(input logic [7:0] presc);
    capture_enable = 1'b0;
    pwm_in = 1'b0;
    wait_clks(8);
    prescaler = presc;
  endtask

  initial begin
    reset_n = 1'b0;
    pwm_in = 1'b0;
    capture_enable = 1'b0;
    prescaler = 8'd0;
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(1);

    // Reset and enable with input low
    capture_enable = 1'b1;
    wait_clks(50);
    check_all_zero("reset_enable");

    // prescaler=0, 25/75 for three periods
    for (int i = 0; i < 3; i++) expect_meas(8'd100, 8'd25);
    for (int i = 0; i < 3; i++) begin
      drive_pwm(1'b1, 25);
      drive_pwm(1'b0, 75);
    end
    drive_pwm(1'b1, 5);
    idle_gap(8'd4);

    // prescaler=4, 250/250 clk -> 100/50 ticks
    capture_enable = 1'b1;
    wait_clks(10);
    for (int i = 0; i < 2; i++) expect_meas(8'd100, 8'd50);
    for (int i = 0; i < 2; i++) begin
      drive_pwm(1'b1, 250);
      drive_pwm(1'b0, 250);
    end
    drive_pwm(1'b1, 20);
    idle_gap(8'd0);

    // Input already high at enable is not a rise
    pwm_in = 1'b1;
    wait_clks(8);
    capture_enable = 1'b1;
    expect_meas(8'd20, 8'd10);
    wait_clks(10);
    drive_pwm(1'b0, 10);
    drive_pwm(1'b1, 10);
    drive_pwm(1'b0, 10);
    drive_pwm(1'b1, 5);
    idle_gap(8'd0);

    // Stuck high -> saturation overflow, cleared by enable 0->1
    capture_enable = 1'b1;
    wait_clks(5);
    drive_pwm(1'b1, 300);
    @(negedge clk);
    check("overflow_set", capture_overflow, 1);
    check("overflow_level", signal_level, 1);
    capture_enable = 1'b0;
    wait_clks(3);
    @(negedge clk);
    check("overflow_sticky", capture_overflow, 1);
    capture_enable = 1'b1;
    wait_clks(3);
    @(negedge clk);
    check("overflow_cleared", capture_overflow, 0);
    idle_gap(8'd0);

    // 40/60 measurement, then disable mid-period, then reset mid-period
    capture_enable = 1'b1;
    wait_clks(5);
    expect_meas(8'd100, 8'd40);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    drive_pwm(1'b1, 15);
    drive_pwm(1'b0, 2);
    drive_pwm(1'b1, 23);
`else
    drive_pwm(1'b1, 40);
`endif
    drive_pwm(1'b0, 60);
    drive_pwm(1'b1, 20);
    capture_enable = 1'b0;
    wait_clks(3);
    @(negedge clk);
    check("disable_period_held", measured_period, 100);
    check("disable_high_held", measured_high, 40);
    check("disable_state_idle", state_dbg, 0);
    check("disable_no_valid", capture_valid, 0);
    capture_enable = 1'b1;
    wait_clks(5);
    drive_pwm(1'b0, 30);
    drive_pwm(1'b1, 10);
    reset_n = 1'b0;
    wait_clks(2);
    check_all_zero("reset_mid");
    reset_n = 1'b1;
    pwm_in = 1'b0;
    wait_clks(5);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
